// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg
// Shared definitions for the control-word pipeline: stage index constants,
// the multi-cycle-op FSM state type and a helper that sizes the
// multi-cycle-op occupancy counter.
// No ports (package).

package ctrl_pipe_pkg;

    localparam int STG_D = 0;
    localparam int STG_E = 1;
    localparam int STG_M = 2;
    localparam int STG_W = 3;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // clog2 that never returns 0, so a counter for MD_LAT=1 still has one bit
    function automatic int cntWidth(input int lat);
        int w;
        w = $clog2(lat);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// One pipeline stage register with synchronous reset, flush, hold and bubble.
// Priority: reset > flush > hold > bubble > load. Flush and bubble both
// write all zeros, so a killed stage reads as valid=0 / ctrl=0.
// Ports:
//   clk       in   clock
//   reset     in   synchronous active-high reset
//   flush_i   in   clear the stage
//   hold_i    in   keep the current contents
//   bubble_i  in   load all zeros
//   d_i       in   W-bit value loaded when nothing else applies
//   q_o       out  W-bit registered stage contents

module pipe_stage_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         hold_i,
    input  logic         bubble_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next-state selection: flush outranks hold so a stalled stage can still
    // be killed, and hold outranks bubble so a held op is never overwritten.
    always_comb begin
        q_d = d_i;
        if (flush_i) begin
            q_d = '0;
        end else if (hold_i) begin
            q_d = q_q;
        end else if (bubble_i) begin
            q_d = '0;
        end
    end

    // Stage register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe
// Control-word pipeline carrying decoded control bundles from D through
// NSTAGE-1 registered stages (E, M, W, ...), with per-stage valid bits,
// load-use bubble insertion, E flush and a multi-cycle-op FSM that holds E
// for MD_LAT cycles while stalling upstream.
// Optional build macro CTRL_PIPE_PERF_EN adds saturating stall/bubble counters.
// Ports:
//   clk         in   clock
//   reset       in   synchronous active-high reset
//   ctrlD       in   CW-bit decoded control word in D
//   validD      in   D holds a real instruction
//   mdopD       in   D instruction is a multi-cycle op
//   hz_stall    in   load-use stall (hold D, bubble E)
//   flushE      in   kill E contents
//   ctrl_o      out  stage k control word at [(k-1)*CW +: CW]
//   valid_o     out  stage k valid at bit k-1
//   stallD      out  hold fetch/decode registers
//   md_busy     out  multi-cycle FSM in BUSY
//   stall_cnt   out  (CTRL_PIPE_PERF_EN) cycles with stallD=1, saturating
//   bubble_cnt  out  (CTRL_PIPE_PERF_EN) cycles writing a bubble into E or M

module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int            CW        = 15,
    parameter int            NSTAGE    = 4,
    parameter int            MD_LAT    = 4,
    parameter logic [CW-1:0] LATE_MASK = {CW{1'b1}}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CW-1:0]            ctrlD,
    input  logic                     validD,
    input  logic                     mdopD,
    input  logic                     hz_stall,
    input  logic                     flushE,
    output logic [(NSTAGE-1)*CW-1:0] ctrl_o,
    output logic [NSTAGE-2:0]        valid_o,
    output logic                     stallD,
    output logic                     md_busy
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [31:0]              stall_cnt,
    output logic [31:0]              bubble_cnt
`endif
);

    localparam int            CNT_W    = cntWidth(MD_LAT);
    localparam logic          MD_MULTI = 1'(MD_LAT > 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MD_LAT > 1) ? (MD_LAT - 2) : 0);

    logic [CW+1:0] stageEQ;
    logic [CW:0]   laterQ [STG_M:NSTAGE-1];
    logic          validE;
    logic          mdopE;
    logic          mdStall;

    md_state_t        stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD;

    assign validE = stageEQ[CW+1];
    assign mdopE  = stageEQ[CW];

    // Stage chain. E carries {valid, mdop, ctrl}; M onward only needs
    // {valid, ctrl}. M takes a bubble while E is held so the held op is not
    // duplicated downstream, and applies LATE_MASK to drop early-only bits.
    for (genvar k = STG_D + 1; k < NSTAGE; k++) begin : g_stage
        if (k == STG_E) begin : g_e
            pipe_stage_reg #(.W(CW + 2)) u_reg (
                .clk      (clk),
                .reset    (reset),
                .flush_i  (flushE),
                .hold_i   (mdStall),
                .bubble_i (hz_stall),
                .d_i      ({validD, mdopD, ctrlD}),
                .q_o      (stageEQ)
            );
            assign valid_o[k-1]           = stageEQ[CW+1];
            assign ctrl_o[(k-1)*CW +: CW] = stageEQ[CW-1:0];
        end else if (k == STG_M) begin : g_m
            pipe_stage_reg #(.W(CW + 1)) u_reg (
                .clk      (clk),
                .reset    (reset),
                .flush_i  (1'b0),
                .hold_i   (1'b0),
                .bubble_i (mdStall),
                .d_i      ({stageEQ[CW+1], stageEQ[CW-1:0] & LATE_MASK}),
                .q_o      (laterQ[k])
            );
            assign valid_o[k-1]           = laterQ[k][CW];
            assign ctrl_o[(k-1)*CW +: CW] = laterQ[k][CW-1:0];
        end else if (k >= STG_W) begin : g_late
            pipe_stage_reg #(.W(CW + 1)) u_reg (
                .clk      (clk),
                .reset    (reset),
                .flush_i  (1'b0),
                .hold_i   (1'b0),
                .bubble_i (1'b0),
                .d_i      (laterQ[k-1]),
                .q_o      (laterQ[k])
            );
            assign valid_o[k-1]           = laterQ[k][CW];
            assign ctrl_o[(k-1)*CW +: CW] = laterQ[k][CW-1:0];
        end
    end

    // Multi-cycle-op FSM next state and stall. The IDLE cycle in which an
    // mdop sits in E already counts as the first stall cycle, so BUSY only
    // needs MD_LAT-2 more stall cycles plus one release cycle with cnt==0.
    // A flush aborts the op and returns to IDLE at the same edge as E clears.
    always_comb begin
        stateD  = stateQ;
        cntD    = cntQ;
        mdStall = 1'b0;
        case (stateQ)
            MD_IDLE: begin
                if (validE && mdopE && MD_MULTI) begin
                    mdStall = 1'b1;
                    if (!flushE) begin
                        stateD = MD_BUSY;
                        cntD   = CNT_LOAD;
                    end
                end
            end
            MD_BUSY: begin
                mdStall = (cntQ != '0);
                if (flushE) begin
                    stateD = MD_IDLE;
                    cntD   = '0;
                end else if (cntQ != '0) begin
                    cntD = cntQ - 1'b1;
                end else begin
                    stateD = MD_IDLE;
                end
            end
            default: begin
                stateD = MD_IDLE;
                cntD   = '0;
            end
        endcase
    end

    // FSM state and occupancy counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= MD_IDLE;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    assign stallD  = hz_stall | mdStall;
    assign md_busy = (stateQ == MD_BUSY);

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] stallCntQ, stallCntD;
    logic [31:0] bubbleCntQ, bubbleCntD;
    logic        bubbleWrite;

    // A bubble lands in E on an unheld, unflushed load-use stall, and in M
    // on every md stall cycle; the two cases never coincide.
    assign bubbleWrite = (!flushE && !mdStall && hz_stall) || mdStall;

    // Saturating counter increments
    always_comb begin
        stallCntD  = stallCntQ;
        bubbleCntD = bubbleCntQ;
        if (stallD && (stallCntQ != '1)) begin
            stallCntD = stallCntQ + 32'd1;
        end
        if (bubbleWrite && (bubbleCntQ != '1)) begin
            bubbleCntD = bubbleCntQ + 32'd1;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCntQ  <= '0;
            bubbleCntQ <= '0;
        end else begin
            stallCntQ  <= stallCntD;
            bubbleCntQ <= bubbleCntD;
        end
    end

    assign stall_cnt  = stallCntQ;
    assign bubble_cnt = bubbleCntQ;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule
